// File: rtl/seg7_pkg.sv
// Shared field widths, segment encodings and conversion helpers for the
// byte-to-decimal 7-segment display path.
package seg7_pkg;

  localparam int unsigned BIN_W  = 8;
  localparam int unsigned HUND_W = 2;
  localparam int unsigned TENS_W = 4;
  localparam int unsigned ONES_W = 4;
  localparam int unsigned BCD_W  = HUND_W + TENS_W + ONES_W;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEG_W  = 7;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_D0    = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_D1    = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_D2    = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_D3    = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_D4    = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_D5    = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_D6    = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_D7    = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_D8    = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_D9    = 7'b1101111;

  typedef struct packed {
    logic [HUND_W-1:0] hund;
    logic [TENS_W-1:0] tens;
    logic [ONES_W-1:0] ones;
  } bcd_t;

  function automatic logic [NIB_W-1:0] add3(input logic [NIB_W-1:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // Double dabble: correct every nibble, then shift one binary bit in, MSB first.
  function automatic bcd_t bin_to_bcd(input logic [BIN_W-1:0] bin);
    logic [3*NIB_W-1:0] digits;
    logic [BIN_W-1:0]   src;
    digits = '0;
    src    = bin;
    for (int unsigned i = 0; i < BIN_W; i++) begin
      digits[3:0]  = add3(digits[3:0]);
      digits[7:4]  = add3(digits[7:4]);
      digits[11:8] = add3(digits[11:8]);
      digits       = {digits[10:0], src[BIN_W-1]};
      src          = {src[BIN_W-2:0], 1'b0};
    end
    return bcd_t'(digits[BCD_W-1:0]);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to active-high 7-segment pattern; non-decimal codes blank.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_D0;
      4'd1:    seg = SEG_D1;
      4'd2:    seg = SEG_D2;
      4'd3:    seg = SEG_D3;
      4'd4:    seg = SEG_D4;
      4'd5:    seg = SEG_D5;
      4'd6:    seg = SEG_D6;
      4'd7:    seg = SEG_D7;
      4'd8:    seg = SEG_D8;
      4'd9:    seg = SEG_D9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/add_4_bit.sv
// Registered byte-to-decimal converter driving three 7-segment digits,
// with selectable segment polarity and optional leading-zero blanking.
module add_4_bit
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic [9:0] bcd,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic       out_valid
);

  localparam logic [SEG_W-1:0] SEG_OFF = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  bcd_t             conv;
  logic [SEG_W-1:0] raw0, raw1, raw2;
  logic [SEG_W-1:0] lit0, lit1, lit2;
  logic [SEG_W-1:0] drv0, drv1, drv2;
  logic             hund_zero, tens_zero;

  always_comb begin
    conv = bin_to_bcd(in_byte);
  end

  seg7_decoder u_dec_ones (.digit(conv.ones),         .seg(raw0));
  seg7_decoder u_dec_tens (.digit(conv.tens),         .seg(raw1));
  seg7_decoder u_dec_hund (.digit({2'b00, conv.hund}), .seg(raw2));

  // Blanking is decided on the active-high pattern; polarity is applied last.
  always_comb begin
    hund_zero = (conv.hund == '0);
    tens_zero = (conv.tens == '0);
    lit0 = raw0;
    lit1 = (BLANK_LZ && hund_zero && tens_zero) ? SEG_BLANK : raw1;
    lit2 = (BLANK_LZ && hund_zero) ? SEG_BLANK : raw2;
    drv0 = ACTIVE_LOW ? ~lit0 : lit0;
    drv1 = ACTIVE_LOW ? ~lit1 : lit1;
    drv2 = ACTIVE_LOW ? ~lit2 : lit2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd       <= '0;
      seg0      <= SEG_OFF;
      seg1      <= SEG_OFF;
      seg2      <= SEG_OFF;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        bcd  <= conv;
        seg0 <= drv0;
        seg1 <= drv1;
        seg2 <= drv2;
      end
    end
  end

endmodule

// File: tb/tb_add_4_bit.sv
// Directed bench for add_4_bit: three parameter variants share one stimulus
// stream; expectations come from an arithmetic model queued at drive time.
module tb_add_4_bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_byte = '0;
  logic       in_valid = 1'b0;

  logic [9:0] bcd_a, bcd_b, bcd_c;
  logic [6:0] a0, a1, a2, b0, b1, b2, c0, c1, c2;
  logic       ova, ovb, ovc;

  add_4_bit #(.ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .bcd(bcd_a), .seg0(a0), .seg1(a1), .seg2(a2), .out_valid(ova));

  add_4_bit #(.ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .bcd(bcd_b), .seg0(b0), .seg1(b1), .seg2(b2), .out_valid(ovb));

  add_4_bit #(.ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .bcd(bcd_c), .seg0(c0), .seg1(c1), .seg2(c2), .out_valid(ovc));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] bcd;
    logic [6:0] a0, a1, a2, b0, b1, b2, c0, c1, c2;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  exp_t rst_exp;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [6:0] seg_hi(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic exp_t model(input logic [7:0] v);
    exp_t m;
    int h, t, o;
    h = int'(v) / 100;
    t = (int'(v) / 10) % 10;
    o = int'(v) % 10;
    m.bcd = {h[1:0], t[3:0], o[3:0]};
    m.a0 = ~seg_hi(o);
    m.a1 = ~seg_hi(t);
    m.a2 = ~seg_hi(h);
    m.b0 = ~seg_hi(o);
    m.b1 = (h == 0 && t == 0) ? 7'b1111111 : ~seg_hi(t);
    m.b2 = (h == 0) ? 7'b1111111 : ~seg_hi(h);
    m.c0 = seg_hi(o);
    m.c1 = seg_hi(t);
    m.c2 = seg_hi(h);
    return m;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".bcd_a"}, {6'd0, bcd_a}, {6'd0, e.bcd});
    check({tag, ".bcd_b"}, {6'd0, bcd_b}, {6'd0, e.bcd});
    check({tag, ".bcd_c"}, {6'd0, bcd_c}, {6'd0, e.bcd});
    check({tag, ".a0"}, {9'd0, a0}, {9'd0, e.a0});
    check({tag, ".a1"}, {9'd0, a1}, {9'd0, e.a1});
    check({tag, ".a2"}, {9'd0, a2}, {9'd0, e.a2});
    check({tag, ".b0"}, {9'd0, b0}, {9'd0, e.b0});
    check({tag, ".b1"}, {9'd0, b1}, {9'd0, e.b1});
    check({tag, ".b2"}, {9'd0, b2}, {9'd0, e.b2});
    check({tag, ".c0"}, {9'd0, c0}, {9'd0, e.c0});
    check({tag, ".c1"}, {9'd0, c1}, {9'd0, e.c1});
    check({tag, ".c2"}, {9'd0, c2}, {9'd0, e.c2});
  endtask

  // One clock of stimulus; output is compared 1 ns after the sampling edge.
  task automatic step(input string tag, input logic [7:0] v, input logic vld);
    exp_t e;
    @(negedge clk);
    in_byte  = v;
    in_valid = vld;
    if (vld) sb.push_back(model(v));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, {13'd0, ova, ovb, ovc}, vld ? 16'd7 : 16'd0);
    if (ova && sb.size() > 0) begin
      e = sb.pop_front();
      check_out(tag, e);
      last = e;
    end else if (!vld) begin
      check_out({tag, ".hold"}, last);
    end else begin
      check({tag, ".missing_output"}, {15'd0, ova}, 16'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    rst_exp     = '0;
    rst_exp.a0  = 7'h7F; rst_exp.a1 = 7'h7F; rst_exp.a2 = 7'h7F;
    rst_exp.b0  = 7'h7F; rst_exp.b1 = 7'h7F; rst_exp.b2 = 7'h7F;
    last        = rst_exp;

    // Reset state
    #12;
    check("reset.out_valid", {13'd0, ova, ovb, ovc}, 16'd0);
    check_out("reset", rst_exp);
    @(negedge clk);
    rst_n = 1'b1;

    // Max value, then the 99 -> 100 carry across digits back-to-back
    step("ff", 8'hFF, 1'b1);
    check("ff.seg2_literal", {9'd0, a2}, 16'b0100100);
    step("x63", 8'h63, 1'b1);
    step("x64", 8'h64, 1'b1);
    check("x64.seg2_literal", {9'd0, a2}, 16'b1111001);

    // Leading-zero cases
    step("zero", 8'h00, 1'b1);
    check("zero.b0_literal", {9'd0, b0}, 16'b1000000);
    step("ten", 8'h0A, 1'b1);

    // Idle cycles hold the last value while in_byte wanders
    for (int i = 0; i < 5; i++) step("idle", 8'($urandom_range(255)), 1'b0);

    // Full sweep, back-to-back
    for (int i = 0; i < 256; i++) step("sweep", 8'(i), 1'b1);

    step("pre_rst", 8'd37, 1'b1);

    // Mid-stream asynchronous reset with a valid input pending
    @(negedge clk);
    in_byte  = 8'd200;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.out_valid", {13'd0, ova, ovb, ovc}, 16'd0);
    check_out("async_rst", rst_exp);
    @(posedge clk);
    #1;
    check("rst_held.out_valid", {13'd0, ova, ovb, ovc}, 16'd0);
    check_out("rst_held", rst_exp);
    sb.delete();
    last = rst_exp;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    step("post_rst_idle", 8'd99, 1'b0);
    step("post_rst_first", 8'd123, 1'b1);
    step("post_rst_next", 8'd7, 1'b1);

    check("scoreboard_empty", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
